fetch_if_id_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage, which feeds the ID/EX register.
- Owns the 8-bit byte-addressed PC.
- Issues requests on a req/ready instruction-memory port.
- Presents {valid, pc, instruction} to ID.
- Honours stall from the hazard unit and redirect (flush) from branch resolution.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if_id_stage_if_id_reg.sv | 37 +++
 rtl/fetch_if_id_stage.sv | 139 +++++++++++++
 tb/tb_fetch_if_id_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (FETCH, HOLD, DRAIN)
//   FETCH_PC_STEP / FETCH_RESET_PC : default PC increment and reset PC
//   if_id_t       : IF/ID payload {valid, pc, instruction} at default widths
package fetch_pkg;

    localparam int FETCH_PC_W    = 8;
    localparam int FETCH_INSTR_W = 32;
    localparam int FETCH_PC_STEP = 4;
    localparam logic [FETCH_PC_W-1:0] FETCH_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc_q
        HOLD  = 2'd1,   // response captured while ID stalled, no request
        DRAIN = 2'd2    // waiting out a request abandoned by a redirect
    } fetch_state_e;

    typedef struct packed {
        logic                     valid;
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instruction;
    } if_id_t;

endpackage

// File: rtl/fetch_if_id_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst        : clock, async active-high reset (clears everything)
//   flush           : clear valid only (bubble / redirect); wins over load
//   load            : capture {1, load_pc, load_instruction}
//   valid, pc, instruction : registered outputs to ID
// With neither control asserted the register holds.
module if_id_reg #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  logic [PC_WIDTH-1:0]    load_pc,
    input  logic [INSTR_WIDTH-1:0] load_instruction,
    output logic                   valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            pc          <= '0;
            instruction <= '0;
        end else if (flush) begin
            // pc/instruction keep their old values; only valid matters to ID
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= load_pc;
            instruction <= load_instruction;
        end
    end

endmodule

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage: instruction fetch (PC, imem request FSM, hold buffer)
// plus the IF/ID register feeding decode.
//   clk, rst                     : clock, async active-high reset
//   stall                        : ID cannot accept, IF/ID holds
//   redirect_valid, redirect_pc  : taken branch/jump, flush and refetch
//   imem_req, imem_addr          : request port, held stable until imem_ready
//   imem_ready, imem_rdata       : response (sampled only while imem_req=1)
//   id_valid, id_pc, id_instruction : registered IF/ID contents
module fetch_if_id_stage
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = FETCH_PC_W,
    parameter int                  INSTR_WIDTH = FETCH_INSTR_W,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = FETCH_RESET_PC,
    parameter int                  PC_STEP     = FETCH_PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   id_valid,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [INSTR_WIDTH-1:0] id_instruction
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    drain_q, drain_d;
    logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
    logic [INSTR_WIDTH-1:0] hold_ins_q, hold_ins_d;

    logic                   ld, fl;
    logic [PC_WIDTH-1:0]    ld_pc;
    logic [INSTR_WIDTH-1:0] ld_ins;

    // rst gates the request so an in-flight fetch aborts immediately
    assign imem_req  = ((state_q == FETCH) || (state_q == DRAIN)) && !rst;
    assign imem_addr = (state_q == DRAIN) ? drain_q : pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_d    = drain_q;
        hold_pc_d  = hold_pc_q;
        hold_ins_d = hold_ins_q;
        ld         = 1'b0;
        fl         = 1'b0;
        ld_pc      = pc_q;
        ld_ins     = imem_rdata;

        if (redirect_valid) begin
            // Any same-cycle response is dropped; only an unanswered
            // request forces a drain so the memory port stays consistent.
            fl         = 1'b1;
            pc_d       = redirect_pc;
            hold_pc_d  = '0;
            hold_ins_d = '0;
            unique case (state_q)
                FETCH: begin
                    if (!imem_ready) begin
                        state_d = DRAIN;
                        drain_d = pc_q;
                    end
                end
                HOLD:  state_d = FETCH;
                DRAIN: if (imem_ready) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + STEP;
                        if (stall) begin
                            hold_pc_d  = pc_q;
                            hold_ins_d = imem_rdata;
                            state_d    = HOLD;
                        end else begin
                            ld = 1'b1;
                        end
                    end else if (!stall) begin
                        fl = 1'b1;   // bubble into ID
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ld         = 1'b1;
                        ld_pc      = hold_pc_q;
                        ld_ins     = hold_ins_q;
                        hold_pc_d  = '0;
                        hold_ins_d = '0;
                        state_d    = FETCH;
                    end
                end
                DRAIN: if (imem_ready) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            drain_q    <= '0;
            hold_pc_q  <= '0;
            hold_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drain_q    <= drain_d;
            hold_pc_q  <= hold_pc_d;
            hold_ins_q <= hold_ins_d;
        end
    end

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk              (clk),
        .rst              (rst),
        .flush            (fl),
        .load             (ld),
        .load_pc          (ld_pc),
        .load_instruction (ld_ins),
        .valid            (id_valid),
        .pc               (id_pc),
        .instruction      (id_instruction)
    );

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/ready traffic against a behavioural model.
module tb_fetch_if_id_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid, imem_ready;
    logic [7:0]  redirect_pc, imem_addr, id_pc;
    logic [31:0] imem_rdata, id_instruction;
    logic        imem_req, id_valid;

    int checks = 0;
    int errors = 0;

    fetch_if_id_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction)
    );

    always #5 clk = ~clk;

    // Model: next fetch pc, an optional parked instruction, an optional
    // abandoned address still being waited on, and what ID should hold.
    logic [7:0] m_pc, m_daddr;
    bit         m_held, m_drain;
    if_id_t     m_id, m_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_daddr = 8'h00;
        m_held = 0; m_drain = 0;
        m_id = '0; m_hold = '0;
    endtask

    function automatic logic [7:0] m_addr();
        return m_drain ? m_daddr : m_pc;
    endfunction

    task automatic model_step(input bit s, input bit r, input logic [7:0] rp,
                              input bit rdy, input logic [31:0] rd);
        if (r) begin
            m_id.valid = 1'b0;
            if (m_held)       m_held = 0;
            else if (m_drain) begin if (rdy) m_drain = 0; end
            else if (!rdy)    begin m_drain = 1; m_daddr = m_pc; end
            m_pc = rp;
        end else if (m_held) begin
            if (!s) begin m_id = m_hold; m_held = 0; end
        end else if (m_drain) begin
            if (rdy) m_drain = 0;
        end else if (rdy) begin
            if (s) begin m_hold = '{1'b1, m_pc, rd}; m_held = 1; end
            else         m_id   = '{1'b1, m_pc, rd};
            m_pc = m_pc + 8'd4;
        end else if (!s) begin
            m_id.valid = 1'b0;
        end
    endtask

    task automatic compare();
        chk("imem_req", imem_req, !rst && !m_held);
        if (!rst && !m_held) chk("imem_addr", imem_addr, m_addr());
        chk("id_valid", id_valid, m_id.valid);
        chk("id_pc", id_pc, m_id.pc);
        chk("id_instruction", id_instruction, m_id.instruction);
    endtask

    // One clock: drive at negedge, advance model, check at next negedge.
    task automatic cyc(input bit s, input bit r, input logic [7:0] rp, input bit rdy);
        logic [31:0] rd;
        rd = rdy ? (32'h1000 + {24'h0, m_addr()}) : $urandom;
        stall = s; redirect_valid = r; redirect_pc = rp;
        imem_ready = rdy; imem_rdata = rd;
        model_step(s, r, rp, rdy, rd);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_ready = 0; imem_rdata = 0;
        model_reset();
        #12;
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_pc", id_pc, 8'h00);
        chk("rst_instr", id_instruction, 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 8'h00);

        // back-to-back fetch
        cyc(0, 0, 0, 1); chk("bb0_pc", id_pc, 8'h00); chk("bb0_v", id_valid, 1'b1);
        cyc(0, 0, 0, 1); chk("bb1_pc", id_pc, 8'h04); chk("bb1_ins", id_instruction, 32'h1004);
        // two wait cycles on 0x08
        cyc(0, 0, 0, 0); chk("wt0_v", id_valid, 1'b0); chk("wt0_addr", imem_addr, 8'h08);
        cyc(0, 0, 0, 0); chk("wt1_v", id_valid, 1'b0); chk("wt1_addr", imem_addr, 8'h08);
        cyc(0, 0, 0, 1); chk("wt_pc", id_pc, 8'h08); chk("wt_v", id_valid, 1'b1);
        // stall 3 cycles as 0x0C returns
        cyc(1, 0, 0, 1); chk("st0_pc", id_pc, 8'h08); chk("st0_req", imem_req, 1'b0);
        cyc(1, 0, 0, 0); chk("st1_req", imem_req, 1'b0);
        cyc(1, 0, 0, 0); chk("st2_pc", id_pc, 8'h08);
        cyc(0, 0, 0, 0); chk("st_rel_pc", id_pc, 8'h0C); chk("st_rel_addr", imem_addr, 8'h10);
        // park 0x10, then redirect under stall
        cyc(1, 0, 0, 1); chk("pk_pc", id_pc, 8'h0C);
        cyc(1, 1, 8'h40, 0); chk("rs_v", id_valid, 1'b0); chk("rs_addr", imem_addr, 8'h40);
        cyc(0, 0, 0, 1); chk("rs_pc", id_pc, 8'h40); chk("rs_ins", id_instruction, 32'h1040);
        // redirect with same-cycle response, then redirect over outstanding 0x14
        cyc(0, 1, 8'h14, 1); chk("rr_v", id_valid, 1'b0); chk("rr_addr", imem_addr, 8'h14);
        cyc(0, 1, 8'h80, 0); chk("dr0_addr", imem_addr, 8'h14); chk("dr0_req", imem_req, 1'b1);
        cyc(0, 0, 0, 0); chk("dr1_addr", imem_addr, 8'h14);
        cyc(0, 0, 0, 1); chk("dr2_addr", imem_addr, 8'h80); chk("dr2_v", id_valid, 1'b0);
        cyc(0, 0, 0, 1); chk("dr_pc", id_pc, 8'h80); chk("dr_v", id_valid, 1'b1);
        // PC wrap
        cyc(0, 1, 8'hFC, 1); chk("wr_addr", imem_addr, 8'hFC);
        cyc(0, 0, 0, 1); chk("wr0_pc", id_pc, 8'hFC);
        cyc(0, 0, 0, 1); chk("wr1_pc", id_pc, 8'h00); chk("wr1_ins", id_instruction, 32'h1000);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit s, r, rdy;
            logic [7:0] rp;
            s   = ($urandom_range(0, 99) < 30);
            r   = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 60);
            rp  = ($urandom_range(0, 7) == 0) ? 8'hFC : (8'($urandom) & 8'hFC);
            cyc(s, r, rp, rdy);
        end

        // async reset in the middle of a request
        cyc(0, 1, 8'h20, 1);
        cyc(0, 0, 0, 1);
        chk("pre_rst_req", imem_req, 1'b1);
        cyc(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", id_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare();
        cyc(0, 0, 0, 1); chk("arst_pc", id_pc, 8'h00); chk("arst_v", id_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
